// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period capture block.
// Holds FSM states, STATUS codes and the capture/result bundles.
package pwm_capture_pkg;

   localparam int PERIOD = 512;
   localparam int TIME_W = 9;

   typedef logic [TIME_W-1:0] time_t;

   localparam time_t T_LAST = time_t'(PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_e;

   localparam logic [1:0] ST_OK     = 2'b00;
   localparam logic [1:0] ST_LOW    = 2'b01;
   localparam logic [1:0] ST_HIGH   = 2'b10;
   localparam logic [1:0] ST_GLITCH = 2'b11;

   typedef struct packed {
      time_t      rise;
      time_t      fall;
      logic [1:0] n_rise;
      logic [1:0] n_fall;
      logic       glitch;
   } cap_t;

   typedef struct packed {
      cap_t cap;
      logic level;
   } snap_t;

   typedef struct packed {
      time_t      rise;
      time_t      fall;
      time_t      width;
      logic [7:0] phase;
      logic [1:0] status;
   } res_t;

   function automatic logic [1:0] sat_inc(input logic [1:0] n);
      return (n == 2'd2) ? n : n + 2'd1;
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Signal bundle between the capture block and its environment.
// slave is the block side, master the driver/observer side.
interface pwm_capture_if;
   import pwm_capture_pkg::*;

   time_t      TIME_CNT;
   logic       PWM_IN;
   logic       START;
   logic       CONTINUOUS;
   time_t      RISE;
   time_t      FALL;
   time_t      PULSE_WIDTH;
   logic [7:0] PHASE;
   logic [1:0] STATUS;
   logic       DOUT_VALID;
   logic       BUSY;

   modport slave (
      input  TIME_CNT,
      input  PWM_IN,
      input  START,
      input  CONTINUOUS,
      output RISE,
      output FALL,
      output PULSE_WIDTH,
      output PHASE,
      output STATUS,
      output DOUT_VALID,
      output BUSY
   );

   modport master (
      output TIME_CNT,
      output PWM_IN,
      output START,
      output CONTINUOUS,
      input  RISE,
      input  FALL,
      input  PULSE_WIDTH,
      input  PHASE,
      input  STATUS,
      input  DOUT_VALID,
      input  BUSY
   );

endinterface

// File: rtl/pwm_capture_calc.sv
// Result stage: classifies a captured window and derives width/phase.
// One register stage; results hold until the next snapshot.
module pwm_capture_calc
   import pwm_capture_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  in_v,
   input  snap_t snap,
   output res_t  res,
   output logic  valid
);

   res_t  res_q, res_d;
   logic  valid_q, valid_d;
   logic  ok, none;
   time_t pw, ctr;

   assign ok   = !snap.cap.glitch
              && snap.cap.n_rise == 2'd1
              && snap.cap.n_fall == 2'd1;
   assign none = !snap.cap.glitch
              && snap.cap.n_rise == 2'd0
              && snap.cap.n_fall == 2'd0;

   // Widths and centre wrap mod PERIOD by the natural TIME_W width
   assign pw  = snap.cap.fall - snap.cap.rise;
   assign ctr = snap.cap.rise + (pw >> 1);

   always_comb begin
      res_d   = res_q;
      valid_d = in_v;
      if (in_v) begin
         res_d = '0;
         unique case (1'b1)
            ok: begin
               res_d.rise   = snap.cap.rise;
               res_d.fall   = snap.cap.fall;
               res_d.width  = pw;
               res_d.phase  = 8'(ctr >> 1);
               res_d.status = ST_OK;
            end
            none: begin
               res_d.status = snap.level ? ST_HIGH : ST_LOW;
            end
            default: begin
               res_d.status = ST_GLITCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign res   = res_q;
   assign valid = valid_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures rise/fall times of one PWM period against a free-running counter.
// FSM, edge detect and capture live here; arithmetic is in pwm_capture_calc.
module pwm_capture #(
   parameter int TIME_OFFSET = 0
) (
   input logic          CLK,
   input logic          RST,
   pwm_capture_if.slave io
);
   import pwm_capture_pkg::*;

   localparam time_t OFS = time_t'(TIME_OFFSET);

   state_e state_q, state_d;
   logic   pwm_q;
   time_t  time_q;
   cap_t   cap_q, cap_d, cur;
   snap_t  snap_q, snap_d;
   logic   snap_v_q, snap_v_d;

   logic   rise_e, fall_e, last, step_ok;
   time_t  edge_t;
   res_t   res;
   logic   res_v;

   assign rise_e  = io.PWM_IN & ~pwm_q;
   assign fall_e  = ~io.PWM_IN & pwm_q;
   assign last    = io.TIME_CNT == T_LAST;
   assign step_ok = io.TIME_CNT == time_q + time_t'(1);
   assign edge_t  = io.TIME_CNT - OFS;

   // START on the counter's last cycle skips ARM so the next 0 is not missed
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (io.START || io.CONTINUOUS)
               state_d = last ? MEASURE : ARM;
         end
         ARM: begin
            if (last)
               state_d = MEASURE;
         end
         MEASURE: begin
            if (last)
               state_d = io.CONTINUOUS ? MEASURE : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cur = cap_q;
      if (rise_e) begin
         if (cap_q.n_rise == 2'd0)
            cur.rise = edge_t;
         cur.n_rise = sat_inc(cap_q.n_rise);
      end
      if (fall_e) begin
         if (cap_q.n_fall == 2'd0)
            cur.fall = edge_t;
         cur.n_fall = sat_inc(cap_q.n_fall);
      end
      if (!step_ok)
         cur.glitch = 1'b1;

      cap_d    = cap_q;
      snap_d   = snap_q;
      snap_v_d = 1'b0;
      if (state_q == MEASURE) begin
         cap_d = cur;
         if (last) begin
            snap_d.cap   = cur;
            snap_d.level = io.PWM_IN;
            snap_v_d     = 1'b1;
            cap_d        = '0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         pwm_q    <= 1'b0;
         time_q   <= '0;
         cap_q    <= '0;
         snap_q   <= '0;
         snap_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pwm_q    <= io.PWM_IN;
         time_q   <= io.TIME_CNT;
         cap_q    <= cap_d;
         snap_q   <= snap_d;
         snap_v_q <= snap_v_d;
      end
   end

   pwm_capture_calc u_calc (
      .clk   (CLK),
      .rst   (RST),
      .in_v  (snap_v_q),
      .snap  (snap_q),
      .res   (res),
      .valid (res_v)
   );

   assign io.RISE        = res.rise;
   assign io.FALL        = res.fall;
   assign io.PULSE_WIDTH = res.width;
   assign io.PHASE       = res.phase;
   assign io.STATUS      = res.status;
   assign io.DOUT_VALID  = res_v;
   assign io.BUSY        = state_q != IDLE;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: two instances (offset 0 and 1).
// Counter and PWM pattern advance 2ns after each rising edge.
module tb_pwm_capture;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [8:0]   tcnt = '0;
   logic         pwm = 1'b0;
   logic         start0 = 1'b0;
   logic         start1 = 1'b0;
   logic         cont = 1'b0;
   logic         jump = 1'b0;
   logic [511:0] pat = '0;
   int           n_cmp = 0;
   int           n_bad = 0;

   logic [36:0]  res0, res1;

   pwm_capture_if io0();
   pwm_capture_if io1();

   assign io0.TIME_CNT   = tcnt;
   assign io0.PWM_IN     = pwm;
   assign io0.START      = start0;
   assign io0.CONTINUOUS = cont;
   assign io1.TIME_CNT   = tcnt;
   assign io1.PWM_IN     = pwm;
   assign io1.START      = start1;
   assign io1.CONTINUOUS = 1'b0;

   assign res0 = {io0.RISE, io0.FALL, io0.PULSE_WIDTH, io0.PHASE, io0.STATUS};
   assign res1 = {io1.RISE, io1.FALL, io1.PULSE_WIDTH, io1.PHASE, io1.STATUS};

   pwm_capture #(.TIME_OFFSET(0)) dut0 (.CLK(clk), .RST(rst), .io(io0));
   pwm_capture #(.TIME_OFFSET(1)) dut1 (.CLK(clk), .RST(rst), .io(io1));

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         tcnt = tcnt + (jump ? 9'd2 : 9'd1);
         jump = 1'b0;
         pwm  = pat[tcnt];
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic add_win(input int a, input int b);
      for (int i = 0; i < 512; i++)
         if ((a <= b) ? (i >= a && i <= b) : (i >= a || i <= b))
            pat[i] = 1'b1;
   endtask

   task automatic sync_to(input int v);
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (int'(tcnt) == v) break;
      end
   endtask

   task automatic wait_dv(input int which, input int lim, output int n);
      n = 0;
      while (n < lim) begin
         @(negedge clk);
         n++;
         if ((which == 0) ? io0.DOUT_VALID : io1.DOUT_VALID) break;
      end
   endtask

   task automatic pulse0();
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (res0 !== 37'd0) begin
         n_bad++;
         $display("FAIL reset_res0: got %h want 0", res0);
      end
      n_cmp++;
      if ({io0.DOUT_VALID, io0.BUSY, io1.DOUT_VALID, io1.BUSY} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 0000",
            {io0.DOUT_VALID, io0.BUSY, io1.DOUT_VALID, io1.BUSY});
      end
      n_cmp++;
      if (res1 !== 37'd0) begin
         n_bad++;
         $display("FAIL reset_res1: got %h want 0", res1);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_pulse();
      int n;
      pat = '0;
      add_win(100, 199);
      sync_to(20);
      pulse0();
      n_cmp++;
      if (io0.BUSY !== 1'b1) begin
         n_bad++;
         $display("FAIL pulse_busy: got %b want 1", io0.BUSY);
      end
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200) begin
         n_bad++;
         $display("FAIL pulse_dv: got timeout want strobe");
      end
      n_cmp++;
      if (tcnt !== 9'd1) begin
         n_bad++;
         $display("FAIL pulse_dv_time: got %0d want 1", tcnt);
      end
      n_cmp++;
      if (res0 !== {9'd100, 9'd200, 9'd100, 8'd75, 2'b00}) begin
         n_bad++;
         $display("FAIL pulse_res: got %h want %h", res0,
            {9'd100, 9'd200, 9'd100, 8'd75, 2'b00});
      end
      @(negedge clk);
      n_cmp++;
      if ({io0.DOUT_VALID, io0.BUSY} !== 2'b00) begin
         n_bad++;
         $display("FAIL pulse_after: got %b want 00",
            {io0.DOUT_VALID, io0.BUSY});
      end
      n_cmp++;
      if (res0 !== {9'd100, 9'd200, 9'd100, 8'd75, 2'b00}) begin
         n_bad++;
         $display("FAIL pulse_hold: got %h", res0);
      end
   endtask

   task automatic test_wrap();
      int n;
      pat = '0;
      add_win(480, 31);
      sync_to(100);
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {9'd480, 9'd32, 9'd64, 8'd0, 2'b00}) begin
         n_bad++;
         $display("FAIL wrap_res: got %h want %h", res0,
            {9'd480, 9'd32, 9'd64, 8'd0, 2'b00});
      end
   endtask

   task automatic test_const();
      int n;
      pat = '0;
      sync_to(100);
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {35'd0, 2'b01}) begin
         n_bad++;
         $display("FAIL const_low: got %h want 1", res0);
      end
      pat = '1;
      sync_to(100);
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {35'd0, 2'b10}) begin
         n_bad++;
         $display("FAIL const_high: got %h want 2", res0);
      end
   endtask

   task automatic test_two_pulses();
      int n;
      pat = '0;
      add_win(10, 19);
      add_win(300, 309);
      sync_to(100);
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {35'd0, 2'b11}) begin
         n_bad++;
         $display("FAIL two_pulses: got %h want 3", res0);
      end
   endtask

   task automatic test_offset();
      int n;
      pat = '0;
      add_win(101, 200);
      sync_to(20);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_dv(1, 1200, n);
      n_cmp++;
      if (n >= 1200 || res1 !== {9'd100, 9'd200, 9'd100, 8'd75, 2'b00}) begin
         n_bad++;
         $display("FAIL offset_res: got %h want %h", res1,
            {9'd100, 9'd200, 9'd100, 8'd75, 2'b00});
      end
   endtask

   task automatic test_start_at_last();
      int n;
      pat = '0;
      add_win(200, 259);
      sync_to(511);
      pulse0();
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n !== 513) begin
         n_bad++;
         $display("FAIL last_start_lat: got %0d want 513", n);
      end
      n_cmp++;
      if (res0 !== {9'd200, 9'd260, 9'd60, 8'd115, 2'b00}) begin
         n_bad++;
         $display("FAIL last_start_res: got %h want %h", res0,
            {9'd200, 9'd260, 9'd60, 8'd115, 2'b00});
      end
   endtask

   task automatic test_glitch();
      int n;
      pat = '0;
      add_win(100, 199);
      sync_to(5);
      pulse0();
      sync_to(511);
      sync_to(300);
      jump = 1'b1;
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {35'd0, 2'b11}) begin
         n_bad++;
         $display("FAIL glitch: got %h want 3", res0);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      pat = '0;
      add_win(100, 199);
      cont = 1'b1;
      wait_dv(0, 1200, n);
      n_cmp++;
      if (n >= 1200 || res0 !== {9'd100, 9'd200, 9'd100, 8'd75, 2'b00}) begin
         n_bad++;
         $display("FAIL cont_first: got %h", res0);
      end
      for (int k = 0; k < 2; k++) begin
         wait_dv(0, 1200, n);
         n_cmp++;
         if (n !== 512) begin
            n_bad++;
            $display("FAIL cont_period%0d: got %0d want 512", k, n);
         end
         n_cmp++;
         if (res0 !== {9'd100, 9'd200, 9'd100, 8'd75, 2'b00}) begin
            n_bad++;
            $display("FAIL cont_res%0d: got %h", k, res0);
         end
      end
      sync_to(250);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({res0, io0.DOUT_VALID, io0.BUSY} !== 39'd0) begin
         n_bad++;
         $display("FAIL midrst_out: got %h want 0",
            {res0, io0.DOUT_VALID, io0.BUSY});
      end
      cont = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_dv(0, 1100, n);
      n_cmp++;
      if (n !== 1100 || io0.BUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_nostrobe: got n=%0d busy=%b want 1100/0",
            n, io0.BUSY);
      end
   endtask

   initial begin
      test_reset();
      test_pulse();
      test_wrap();
      test_const();
      test_two_pulses();
      test_offset();
      test_start_at_last();
      test_glitch();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter TIME_OFFSET, default 0: pipeline delay in clocks between TIME_CNT and PWM_IN, subtracted mod 512 from every edge time.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 TIME_CNT  input  9  free-running period counter, 0..511, +1 per clock.
REQ-005 PWM_IN  input  1  PWM waveform under measurement, synchronous to CLK.
REQ-006 START  input  1  one-cycle request to measure the next full period.
REQ-007 CONTINUOUS  input  1  when high, windows repeat back-to-back without START.
REQ-008 RISE  output  9  edge time of the rising edge.
REQ-009 FALL  output  9  edge time of the falling edge.
REQ-010 PULSE_WIDTH  output  9  (FALL - RISE) mod 512.
REQ-011 PHASE  output  8  bits [8:1] of pulse centre.
REQ-012 STATUS  output  2  00 ok, 01 constant low, 10 constant high, 11 glitch.
REQ-013 DOUT_VALID  output  1  one-cycle strobe; all result outputs valid while high.
REQ-014 BUSY  output  1  high in ARM or MEASURE.

Function
REQ-015 PWM_IN shall be registered every cycle, independent of state, so the edge detect at TIME_CNT=0 compares against the TIME_CNT=511 sample.
- Rising edge: current 1, previous 0.
- Falling edge: current 0, previous 1.
- Edge time = (TIME_CNT - TIME_OFFSET) mod 512.
REQ-016 FSM states:
- IDLE: on START or CONTINUOUS, go to ARM.
- ARM: on TIME_CNT=511, go to MEASURE.
- MEASURE: spans the 512 cycles TIME_CNT=0..511; on the cycle with TIME_CNT=511, go to ARM's successor per REQ-022, else IDLE.
REQ-017 In MEASURE, the first rise and first fall shall be latched; edge counters shall saturate at 2 per polarity.
REQ-018 At the TIME_CNT=511 cycle of MEASURE, the capture set shall be snapshotted into the calc stage and cleared in the same edge.
REQ-019 Calc stage, one registered cycle:
- PULSE_WIDTH = (FALL - RISE) mod 512.
- Centre = (RISE + floor(PULSE_WIDTH/2)) mod 512.
- PHASE = centre[8:1].
REQ-020 DOUT_VALID shall be high exactly 2 clocks after the last MEASURE sample cycle, for one cycle.
- Result outputs hold until the next DOUT_VALID.
REQ-021 STATUS classification:
- Exactly one rise and one fall: 00.
- No edges, sampled level 0: 01.
- No edges, sampled level 1: 10.
- Any other edge count: 11.
- For STATUS != 00: RISE = FALL = PULSE_WIDTH = PHASE = 0.
REQ-022 CONTINUOUS high at end of MEASURE shall re-enter MEASURE directly, with no gap window.
REQ-023 START while BUSY shall be ignored.
REQ-024 START and the ARM exit on the same cycle shall not be lost; START in IDLE arms for the next TIME_CNT=0.
REQ-025 In MEASURE, a TIME_CNT not equal to previous+1 mod 512 shall force STATUS=11 for that window.

Reset
REQ-026 RST shall asynchronously force:
- FSM to IDLE.
- All outputs to 0, including DOUT_VALID and BUSY.
- Capture registers, edge counters and the PWM_IN history to 0.
REQ-027 RST asserted mid-MEASURE shall discard the window; no DOUT_VALID is produced, and a new START or CONTINUOUS is required after release.

Structure
REQ-028 Package pwm_capture_pkg shall hold:
- The state enum (IDLE, ARM, MEASURE).
- The STATUS encodings.
- PERIOD=512 and TIME_W=9.
REQ-029 Sub-module pwm_capture_calc shall hold the registered arithmetic of REQ-019 and REQ-021; the top holds the FSM, edge detect and capture.

Verification
REQ-030 High on TIME_CNT 100..199 -> RISE=100, FALL=200, PULSE_WIDTH=100, PHASE=75, STATUS=00.
REQ-031 High on 480..511 and 0..31 (wrap) -> RISE=480, FALL=32, PULSE_WIDTH=64, PHASE=0, STATUS=00.
REQ-032 Constant low -> STATUS=01; constant high -> STATUS=10; all other outputs 0 in both cases.
REQ-033 Two pulses in one window (10..19 and 300..309) -> STATUS=11, outputs 0.
REQ-034 TIME_OFFSET=1, high on 101..200 -> RISE=100, FALL=200, PHASE=75.
REQ-035 CONTINUOUS=1 for 3 periods -> DOUT_VALID every 512 clocks; RST at TIME_CNT=250 -> all outputs 0, no strobe.
